// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrates one register-file write port between ALU and load unit; REGFILE_CLEAR_EN adds a post-reset x1..x31 clear.
// Latency: 1 cycle from acceptance (valid & ready on a rising edge) to registered RegW/A3/write.
// Backpressure: ready is combinational; requesters hold valid/rd/data until accepted (no buffering); both readies low while busy.
module regfile_wb_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        RegW,
    output logic [4:0]  A3,
    output logic [31:0] write,
    output logic        busy
);

    // Clear-sequencer view seen by the arbiter and the write-port mux
    logic        w_busy;
    logic        w_clr_wr;
    logic [4:0]  w_clr_addr;

    // Arbitration
    logic        r_last_mem;
    logic        w_mem_wins;
    logic        w_gnt_alu;
    logic        w_gnt_mem;

    // Registered write port and its next value
    logic        r_regw;
    logic [4:0]  r_a3;
    logic [31:0] r_wdata;
    logic        w_wr_en;
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;

`ifdef REGFILE_CLEAR_EN
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_clr_cnt;

    // State register: CLEAR out of reset, RUN once the sweep has finished
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: the counter wraps to 0 after x31 is written, which ends the sweep
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == 5'd0) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
        endcase
    end

    // FSM outputs: busy for the whole CLEAR state, a write only while the counter is 1..31
    always_comb begin
        w_busy     = 1'b0;
        w_clr_wr   = 1'b0;
        w_clr_addr = r_clr_cnt;
        if (r_state == ST_CLEAR) begin
            w_busy   = 1'b1;
            w_clr_wr = (r_clr_cnt != 5'd0);
        end
    end

    // Clear address counter: starts at x1, stops after wrapping past x31
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_cnt <= 5'd1;
        end else if ((r_state == ST_CLEAR) && (r_clr_cnt != 5'd0)) begin
            r_clr_cnt <= r_clr_cnt + 5'd1;
        end
    end
`else
    assign w_busy     = 1'b0;
    assign w_clr_wr   = 1'b0;
    assign w_clr_addr = 5'd0;
`endif

    // Grant decision: a lone requester always wins; on conflict RR picks the one not granted last, else mem
    always_comb begin
        if (ROUND_ROBIN != 0) begin
            w_mem_wins = ~r_last_mem;
        end else begin
            w_mem_wins = 1'b1;
        end
        w_gnt_mem = ~w_busy & mem_valid & (~alu_valid | w_mem_wins);
        w_gnt_alu = ~w_busy & alu_valid & ~w_gnt_mem;
    end

    // Last-grant tracker: updated on every grant, including those that target x0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_mem <= 1'b0;
        end else if (w_gnt_mem) begin
            r_last_mem <= 1'b1;
        end else if (w_gnt_alu) begin
            r_last_mem <= 1'b0;
        end
    end

    // Write-port mux: clear sweep, then the granted requester; x0 grants produce no write
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_a3;
        w_wr_data = r_wdata;
        if (w_clr_wr) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_clr_addr;
            w_wr_data = 32'd0;
        end else if (w_gnt_mem && (mem_rd != 5'd0)) begin
            w_wr_en   = 1'b1;
            w_wr_addr = mem_rd;
            w_wr_data = mem_data;
        end else if (w_gnt_alu && (alu_rd != 5'd0)) begin
            w_wr_en   = 1'b1;
            w_wr_addr = alu_rd;
            w_wr_data = alu_data;
        end
    end

    // Write-port registers: address and data hold their last values when no write occurs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regw  <= 1'b0;
            r_a3    <= 5'd0;
            r_wdata <= 32'd0;
        end else begin
            r_regw <= w_wr_en;
            if (w_wr_en) begin
                r_a3    <= w_wr_addr;
                r_wdata <= w_wr_data;
            end
        end
    end

    assign alu_ready = w_gnt_alu;
    assign mem_ready = w_gnt_mem;
    assign RegW      = r_regw;
    assign A3        = r_a3;
    assign write     = r_wdata;
    assign busy      = w_busy;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: instance 0 is round-robin, instance 1 is fixed priority.
// Directed scenarios use literal expected values; the random scenario uses a behavioural model.
// Define REGFILE_CLEAR_EN for both bench and RTL to exercise the clear sequence.
module tb_regfile_wb_arbiter;

    localparam int NONE = 0;
    localparam int ALU  = 1;
    localparam int MEM  = 2;

`ifdef REGFILE_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid [2];
    logic [4:0]  alu_rd    [2];
    logic [31:0] alu_data  [2];
    logic        alu_ready [2];
    logic        mem_valid [2];
    logic [4:0]  mem_rd    [2];
    logic [31:0] mem_data  [2];
    logic        mem_ready [2];
    logic        regw      [2];
    logic [4:0]  a3        [2];
    logic [31:0] wdata     [2];
    logic        busy      [2];

    int checks;
    int errors;

    // Behavioural model state, one entry per instance
    bit          m_last_mem [2];
    logic        m_regw     [2];
    logic [4:0]  m_a3       [2];
    logic [31:0] m_wr       [2];
    logic        m_busy     [2];
    int          m_clr_next [2];
    int          m_last_g   [2];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid[0]), .alu_rd(alu_rd[0]), .alu_data(alu_data[0]), .alu_ready(alu_ready[0]),
        .mem_valid(mem_valid[0]), .mem_rd(mem_rd[0]), .mem_data(mem_data[0]), .mem_ready(mem_ready[0]),
        .RegW(regw[0]), .A3(a3[0]), .write(wdata[0]), .busy(busy[0])
    );

    regfile_wb_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid[1]), .alu_rd(alu_rd[1]), .alu_data(alu_data[1]), .alu_ready(alu_ready[1]),
        .mem_valid(mem_valid[1]), .mem_rd(mem_rd[1]), .mem_data(mem_data[1]), .mem_ready(mem_ready[1]),
        .RegW(regw[1]), .A3(a3[1]), .write(wdata[1]), .busy(busy[1])
    );

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_last_mem[i] = 1'b0;
            m_regw[i]     = 1'b0;
            m_a3[i]       = 5'd0;
            m_wr[i]       = 32'd0;
            m_busy[i]     = CLR_EN;
            m_clr_next[i] = 1;
            m_last_g[i]   = NONE;
        end
    endfunction

    // Who wins this cycle: nobody while clearing; lone requester wins; conflicts by policy
    function automatic int model_grant(int i);
        if (m_busy[i]) return NONE;
        if (alu_valid[i] && mem_valid[i]) begin
            if (i == 1) return MEM;
            return m_last_mem[i] ? ALU : MEM;
        end
        if (alu_valid[i]) return ALU;
        if (mem_valid[i]) return MEM;
        return NONE;
    endfunction

    function automatic void model_apply(int i, int g);
        logic [4:0]  rd;
        logic [31:0] d;
        m_last_g[i] = g;
        if (m_busy[i]) begin
            if (m_clr_next[i] <= 31) begin
                m_regw[i] = 1'b1;
                m_a3[i]   = 5'(m_clr_next[i]);
                m_wr[i]   = 32'd0;
                m_clr_next[i]++;
            end else begin
                m_busy[i] = 1'b0;
                m_regw[i] = 1'b0;
            end
        end else if (g == NONE) begin
            m_regw[i] = 1'b0;
        end else begin
            m_last_mem[i] = (g == MEM);
            rd = (g == MEM) ? mem_rd[i] : alu_rd[i];
            d  = (g == MEM) ? mem_data[i] : alu_data[i];
            if (rd == 5'd0) begin
                m_regw[i] = 1'b0;
            end else begin
                m_regw[i] = 1'b1;
                m_a3[i]   = rd;
                m_wr[i]   = d;
            end
        end
    endfunction

    // Advance one rising edge and the model with it; returns #1 after the edge
    task automatic tick();
        int g [2];
        for (int i = 0; i < 2; i++) g[i] = model_grant(i);
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) model_apply(i, g[i]);
        end
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            alu_valid[i] = 1'b0; alu_rd[i] = 5'd0; alu_data[i] = 32'd0;
            mem_valid[i] = 1'b0; mem_rd[i] = 5'd0; mem_data[i] = 32'd0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40 && (m_busy[0] || m_busy[1]); k++) tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++; if (regw[i] !== 1'b0) begin errors++; $display("FAIL reset RegW[%0d]: got %b expected 0", i, regw[i]); end
            checks++; if (a3[i] !== 5'd0) begin errors++; $display("FAIL reset A3[%0d]: got %0d expected 0", i, a3[i]); end
            checks++; if (wdata[i] !== 32'd0) begin errors++; $display("FAIL reset write[%0d]: got %0h expected 0", i, wdata[i]); end
            checks++; if (busy[i] !== CLR_EN) begin errors++; $display("FAIL reset busy[%0d]: got %b expected %b", i, busy[i], CLR_EN); end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40 && (m_busy[0] || m_busy[1]); k++) tick();
    endtask

`ifdef REGFILE_CLEAR_EN
    task automatic test_clear();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        alu_valid[0] = 1'b1; alu_rd[0] = 5'd3; alu_data[0] = 32'h1234;
        for (int k = 1; k <= 32; k++) begin
            #1;
            checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL clear busy cycle %0d: got %b expected 1", k, busy[0]); end
            checks++; if (alu_ready[0] !== 1'b0) begin errors++; $display("FAIL clear alu_ready cycle %0d: got %b expected 0", k, alu_ready[0]); end
            tick();
            if (k <= 31) begin
                checks++;
                if (regw[0] !== 1'b1 || a3[0] !== 5'(k) || wdata[0] !== 32'd0) begin
                    errors++; $display("FAIL clear write %0d: got RegW=%b A3=%0d write=%0h expected 1/%0d/0", k, regw[0], a3[0], wdata[0], k);
                end
            end else begin
                checks++; if (busy[0] !== 1'b0 || regw[0] !== 1'b0) begin errors++; $display("FAIL clear end: got busy=%b RegW=%b expected 0/0", busy[0], regw[0]); end
            end
            @(negedge clk);
        end
        #1;
        checks++; if (alu_ready[0] !== 1'b1) begin errors++; $display("FAIL clear post alu_ready: got %b expected 1", alu_ready[0]); end
        tick();
        alu_valid[0] = 1'b0;
        checks++;
        if (regw[0] !== 1'b1 || a3[0] !== 5'd3 || wdata[0] !== 32'h1234) begin
            errors++; $display("FAIL clear post write: got %b/%0d/%0h expected 1/3/1234", regw[0], a3[0], wdata[0]);
        end
    endtask

    task automatic test_mid_clear_reset();
        do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        checks++; if (a3[0] !== 5'd10) begin errors++; $display("FAIL midclr pre A3: got %0d expected 10", a3[0]); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (regw[0] !== 1'b0 || a3[0] !== 5'd0) begin errors++; $display("FAIL midclr async: got RegW=%b A3=%0d expected 0/0", regw[0], a3[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (regw[0] !== 1'b1 || a3[0] !== 5'd1) begin errors++; $display("FAIL midclr restart: got RegW=%b A3=%0d expected 1/1", regw[0], a3[0]); end
        for (int k = 0; k < 40 && (m_busy[0] || m_busy[1]); k++) tick();
    endtask
`endif

    task automatic test_single_alu();
        @(negedge clk);
        clear_inputs();
        alu_valid[0] = 1'b1; alu_rd[0] = 5'd1; alu_data[0] = 32'd50;
        #1;
        checks++; if (alu_ready[0] !== 1'b1) begin errors++; $display("FAIL single alu_ready: got %b expected 1", alu_ready[0]); end
        checks++; if (mem_ready[0] !== 1'b0) begin errors++; $display("FAIL single mem_ready: got %b expected 0", mem_ready[0]); end
        tick();
        alu_valid[0] = 1'b0;
        checks++;
        if (regw[0] !== 1'b1 || a3[0] !== 5'd1 || wdata[0] !== 32'd50) begin
            errors++; $display("FAIL single write: got %b/%0d/%0d expected 1/1/50", regw[0], a3[0], wdata[0]);
        end
        tick();
        checks++;
        if (regw[0] !== 1'b0 || a3[0] !== 5'd1 || wdata[0] !== 32'd50) begin
            errors++; $display("FAIL single idle hold: got %b/%0d/%0d expected 0/1/50", regw[0], a3[0], wdata[0]);
        end
    endtask

    task automatic test_first_conflict();
        do_reset();
        @(negedge clk);
        alu_valid[0] = 1'b1; alu_rd[0] = 5'd5; alu_data[0] = 32'd80;
        mem_valid[0] = 1'b1; mem_rd[0] = 5'd2; mem_data[0] = 32'd7;
        #1;
        checks++; if (mem_ready[0] !== 1'b1 || alu_ready[0] !== 1'b0) begin errors++; $display("FAIL conflict1 ready: got mem=%b alu=%b expected 1/0", mem_ready[0], alu_ready[0]); end
        tick();
        checks++; if (regw[0] !== 1'b1 || a3[0] !== 5'd2 || wdata[0] !== 32'd7) begin errors++; $display("FAIL conflict1 write: got %b/%0d/%0d expected 1/2/7", regw[0], a3[0], wdata[0]); end
        mem_rd[0] = 5'd3; mem_data[0] = 32'd9;
        #1;
        checks++; if (alu_ready[0] !== 1'b1 || mem_ready[0] !== 1'b0) begin errors++; $display("FAIL conflict2 ready: got alu=%b mem=%b expected 1/0", alu_ready[0], mem_ready[0]); end
        tick();
        checks++; if (regw[0] !== 1'b1 || a3[0] !== 5'd5 || wdata[0] !== 32'd80) begin errors++; $display("FAIL conflict2 write: got %b/%0d/%0d expected 1/5/80", regw[0], a3[0], wdata[0]); end
        alu_rd[0] = 5'd6; alu_data[0] = 32'd11;
        #1;
        checks++; if (mem_ready[0] !== 1'b1 || alu_ready[0] !== 1'b0) begin errors++; $display("FAIL conflict3 ready: got mem=%b alu=%b expected 1/0", mem_ready[0], alu_ready[0]); end
        tick();
        checks++; if (regw[0] !== 1'b1 || a3[0] !== 5'd3 || wdata[0] !== 32'd9) begin errors++; $display("FAIL conflict3 write: got %b/%0d/%0d expected 1/3/9", regw[0], a3[0], wdata[0]); end
        clear_inputs();
        tick();
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        clear_inputs();
        alu_valid[1] = 1'b1; alu_rd[1] = 5'd7; alu_data[1] = 32'hAA;
        for (int c = 0; c < 3; c++) begin
            mem_valid[1] = 1'b1; mem_rd[1] = 5'(c + 10); mem_data[1] = 32'(c + 100);
            #1;
            checks++; if (mem_ready[1] !== 1'b1 || alu_ready[1] !== 1'b0) begin errors++; $display("FAIL fixed ready c%0d: got mem=%b alu=%b expected 1/0", c, mem_ready[1], alu_ready[1]); end
            tick();
            checks++;
            if (regw[1] !== 1'b1 || a3[1] !== 5'(c + 10) || wdata[1] !== 32'(c + 100)) begin
                errors++; $display("FAIL fixed write c%0d: got %b/%0d/%0d expected 1/%0d/%0d", c, regw[1], a3[1], wdata[1], c + 10, c + 100);
            end
        end
        mem_valid[1] = 1'b0;
        #1;
        checks++; if (alu_ready[1] !== 1'b1) begin errors++; $display("FAIL fixed alu after: got %b expected 1", alu_ready[1]); end
        tick();
        checks++; if (a3[1] !== 5'd7 || wdata[1] !== 32'hAA) begin errors++; $display("FAIL fixed alu write: got %0d/%0h expected 7/aa", a3[1], wdata[1]); end
        clear_inputs();
    endtask

    task automatic test_x0();
        @(negedge clk);
        clear_inputs();
        mem_valid[0] = 1'b1; mem_rd[0] = 5'd4; mem_data[0] = 32'h44;
        tick();
        mem_valid[0] = 1'b0;
        alu_valid[0] = 1'b1; alu_rd[0] = 5'd0; alu_data[0] = 32'hFFFFFFFF;
        #1;
        checks++; if (alu_ready[0] !== 1'b1) begin errors++; $display("FAIL x0 alu_ready: got %b expected 1", alu_ready[0]); end
        tick();
        checks++;
        if (regw[0] !== 1'b0 || a3[0] !== 5'd4 || wdata[0] !== 32'h44) begin
            errors++; $display("FAIL x0 no write: got %b/%0d/%0h expected 0/4/44", regw[0], a3[0], wdata[0]);
        end
        alu_rd[0] = 5'd9; alu_data[0] = 32'h99;
        mem_valid[0] = 1'b1; mem_rd[0] = 5'd8; mem_data[0] = 32'h88;
        #1;
        checks++; if (mem_ready[0] !== 1'b1 || alu_ready[0] !== 1'b0) begin errors++; $display("FAIL x0 last_grant: got mem=%b alu=%b expected 1/0", mem_ready[0], alu_ready[0]); end
        tick();
        checks++; if (a3[0] !== 5'd8 || wdata[0] !== 32'h88) begin errors++; $display("FAIL x0 follow write: got %0d/%0h expected 8/88", a3[0], wdata[0]); end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        int g;
        @(negedge clk);
        clear_inputs();
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!(alu_valid[i] && m_last_g[i] != ALU)) begin
                    alu_valid[i] = 1'($urandom_range(0, 1));
                    alu_rd[i]    = 5'($urandom_range(0, 31));
                    alu_data[i]  = $urandom;
                end
                if (!(mem_valid[i] && m_last_g[i] != MEM)) begin
                    mem_valid[i] = 1'($urandom_range(0, 1));
                    mem_rd[i]    = 5'($urandom_range(0, 31));
                    mem_data[i]  = $urandom;
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                g = model_grant(i);
                checks++;
                if (alu_ready[i] !== (g == ALU) || mem_ready[i] !== (g == MEM)) begin
                    errors++; $display("FAIL random ready[%0d] n%0d: got alu=%b mem=%b expected grant %0d", i, n, alu_ready[i], mem_ready[i], g);
                end
            end
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (regw[i] !== m_regw[i] || a3[i] !== m_a3[i] || wdata[i] !== m_wr[i] || busy[i] !== m_busy[i]) begin
                    errors++; $display("FAIL random out[%0d] n%0d: got %b/%0d/%0h/%b expected %b/%0d/%0h/%b", i, n,
                                       regw[i], a3[i], wdata[i], busy[i], m_regw[i], m_a3[i], m_wr[i], m_busy[i]);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
`ifdef REGFILE_CLEAR_EN
        test_clear();
        test_mid_clear_reset();
`endif
        test_single_alu();
        test_first_conflict();
        test_fixed_priority();
        test_x0();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1: 1 = round-robin arbitration on conflict; 0 = fixed priority, mem always wins.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port alu_valid  input  1  ALU writeback request.
REQ-005 SHALL have port alu_rd  input  5  ALU destination register.
REQ-006 SHALL have port alu_data  input  32  ALU writeback value.
REQ-007 SHALL have port alu_ready  output  1  ALU request accepted this cycle.
REQ-008 SHALL have port mem_valid  input  1  load-unit writeback request.
REQ-009 SHALL have port mem_rd  input  5  load destination register.
REQ-010 SHALL have port mem_data  input  32  load writeback value.
REQ-011 SHALL have port mem_ready  output  1  load request accepted this cycle.
REQ-012 SHALL have port RegW  output  1  register-file write enable, registered.
REQ-013 SHALL have port A3  output  5  register-file write address, registered.
REQ-014 SHALL have port write  output  32  register-file write data, registered.
REQ-015 SHALL have port busy  output  1  clear sequence in progress; no requests accepted.

Function
REQ-016 SHALL share the single register-file write port between ALU and mem requesters; at most one grant per cycle.
REQ-017 SHALL treat a request as accepted when valid and ready are both 1 on a rising edge; ready is combinational from valid, arbiter state and busy.
REQ-018 SHALL require requesters to hold valid, rd and data stable until accepted; the arbiter does not buffer them.
REQ-019 SHALL, with only one valid in RUN, assert that requester's ready in the same cycle.
REQ-020 SHALL, on simultaneous valid with ROUND_ROBIN=1, grant the requester not granted last (last_grant flop, updated on every grant); with ROUND_ROBIN=0 grant mem.
REQ-021 SHALL drive RegW=1, A3=rd, write=data in the cycle after acceptance (latency 1); RegW=0 in any cycle after no acceptance.
REQ-022 SHALL accept a request with rd=0 normally (consumes the grant, updates last_grant) but keep RegW=0 for it; x0 is never written.
REQ-023 SHALL hold A3 and write at their last values when RegW=0.
REQ-024 SHALL deassert both ready outputs whenever busy=1.
REQ-025 SHALL implement FSM states CLEAR and RUN: CLEAR to RUN after writing register 31; RUN is terminal until reset.

Reset
REQ-026 SHALL, while rst_n=0, force RegW=0, A3=0, write=0, last_grant=ALU (so mem wins the first conflict), clear counter=1.
REQ-027 SHALL force busy=1 and state=CLEAR during reset when REGFILE_CLEAR_EN is defined, otherwise busy=0 and state=RUN.
REQ-028 SHALL abandon any in-flight write or clear sequence on reset assertion mid-operation; the sequence restarts from register 1 after release.

Configuration
REQ-029 SHALL compile the clear sequencer only when macro REGFILE_CLEAR_EN is defined.
REQ-030 SHALL, with REGFILE_CLEAR_EN, from the first edge after reset release drive RegW=1, write=0, A3=1,2,...,31 on 31 consecutive cycles, then busy=0 and enter RUN on the next edge.
REQ-031 SHALL, without REGFILE_CLEAR_EN, omit counter and CLEAR state, tie busy=0 and accept requests from the first edge after reset.

Verification
REQ-032 SHALL cover: alu_valid=1, alu_rd=1, alu_data=50, mem_valid=0 -> alu_ready=1 same cycle; next cycle RegW=1, A3=1, write=50.
REQ-033 SHALL cover: first conflict after reset, alu (rd=5, 80) and mem (rd=2, 7) held valid, ROUND_ROBIN=1 -> mem granted first (A3=2, write=7), alu next cycle (A3=5, write=80); back-to-back RegW=1.
REQ-034 SHALL cover: ROUND_ROBIN=0, both valid for 3 cycles with mem re-requesting -> mem granted all 3 cycles, alu_ready=0 throughout.
REQ-035 SHALL cover: alu_valid=1, alu_rd=0, alu_data=32'hFFFFFFFF -> alu_ready=1, following cycle RegW=0, A3/write unchanged.
REQ-036 SHALL cover with REGFILE_CLEAR_EN: release rst_n, alu_valid=1 -> busy=1 and alu_ready=0 for 31 cycles with A3=1..31, write=0; then busy=0 and alu accepted.
REQ-037 SHALL cover: rst_n asserted while A3=10 in CLEAR -> RegW=0, A3=0 immediately (asynchronous); after release sequence restarts at A3=1.
